cpu_sequencer: RTL

Control unit for the 8-bit accumulator CPU. It owns PC, AR, IR, AC and the state counter SC, and sequences fetch / decode / indirect / operand / execute over the 16x8 synchronous memory and the external combinational ALU. It sits between the memory block and the ALU and is the only driver of memory address, write enable and ALU enable.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/cpu_seq_decode.sv | 38 +++
 rtl/cpu_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, sequencer states, IR fields.
// Opcode constants are also used by the external ALU.
package cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_CMA = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_LOADIR  = 3'd1,
    ST_DECODE  = 3'd2,
    ST_IND_RD  = 3'd3,
    ST_IND_LD  = 3'd4,
    ST_OPERAND = 3'd5,
    ST_EXEC    = 3'd6,
    ST_HALT    = 3'd7
  } state_t;

  localparam int IR_I_BIT   = 7;
  localparam int IR_OP_HI   = 6;
  localparam int IR_OP_LO   = 4;
  localparam int IR_ADDR_HI = 3;
  localparam int IR_ADDR_LO = 0;

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational opcode classifier for the sequencer; zero latency, no flow control.
// Register-reference ops (SHL, CMA, HLT) never touch memory.
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  logic [2:0] opcode,
  output logic       is_memref,
  output logic       is_store,
  output logic       is_load,
  output logic       is_halt,
  output logic       is_alu_op
);

  always_comb begin
    is_memref = 1'b0;
    is_store  = 1'b0;
    is_load   = 1'b0;
    is_halt   = 1'b0;
    is_alu_op = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_XOR: begin
        is_memref = 1'b1;
        is_alu_op = 1'b1;
      end
      OP_SHL, OP_CMA: is_alu_op = 1'b1;
      OP_LDA: begin
        is_memref = 1'b1;
        is_load   = 1'b1;
      end
      OP_STA: begin
        is_memref = 1'b1;
        is_store  = 1'b1;
      end
      default: is_halt = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Accumulator CPU control unit: multi-cycle fetch/decode/indirect/operand/execute sequencer.
// 4-7 cycles per instruction; run is honoured only at the FETCH boundary, RST overrides all.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 4'h0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        alu_opcode,
  output logic              alu_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic [2:0]        sc,
  output logic              halted
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_q, ar_q;
  logic [DATA_W-1:0] ir_q, ac_q;
  logic              we_raw, alu_raw;
  logic              is_memref, is_store, is_load, is_halt, is_alu_op;

  cpu_seq_decode u_decode (
    .opcode    (ir_q[IR_OP_HI:IR_OP_LO]),
    .is_memref (is_memref),
    .is_store  (is_store),
    .is_load   (is_load),
    .is_halt   (is_halt),
    .is_alu_op (is_alu_op)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_FETCH;
      pc_q  <= RESET_PC;
      ar_q  <= '0;
      ir_q  <= '0;
      ac_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_LOADIR: begin
          ir_q <= mem_rdata;
          pc_q <= pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        ST_DECODE: ar_q <= ir_q[ADDR_W-1:0];
        // Pointer word: only the low address bits are meaningful.
        ST_IND_LD: ar_q <= mem_rdata[ADDR_W-1:0];
        ST_EXEC: begin
          if (is_load)        ac_q <= mem_rdata;
          else if (is_alu_op) ac_q <= alu_result;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = pc_q;
    we_raw    = 1'b0;
    alu_raw   = 1'b0;
    case (state)
      ST_FETCH:  if (run) state_nxt = ST_LOADIR;
      ST_LOADIR: state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (is_halt)              state_nxt = ST_HALT;
        else if (!is_memref)      state_nxt = ST_EXEC;
        else if (ir_q[IR_I_BIT])  state_nxt = ST_IND_RD;
        else                      state_nxt = ST_OPERAND;
      end
      ST_IND_RD: begin
        mem_addr  = ar_q;
        state_nxt = ST_IND_LD;
      end
      ST_IND_LD: state_nxt = ST_OPERAND;
      ST_OPERAND: begin
        mem_addr = ar_q;
        if (is_store) begin
          we_raw    = 1'b1;
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_raw   = is_alu_op;
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_HALT;
    endcase
  end

  // Strobes are masked by RST so a reset landing mid-STA never commits a write.
  assign mem_we     = we_raw & ~RST;
  assign alu_en     = alu_raw & ~RST;
  assign mem_wdata  = ac_q;
  assign alu_opcode = ir_q[IR_OP_HI:IR_OP_LO];
  assign alu_a      = ac_q;
  assign alu_b      = mem_rdata;
  assign pc         = pc_q;
  assign acc        = ac_q;
  assign sc         = state;
  assign halted     = (state == ST_HALT);

endmodule
